feature_map_loader_axis: RTL
============================

FEATURE_MAP_LOADER_AXIS -- requirements
Module: feature_map_loader_axis

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, width of the DMA MM2S stream; only 64 is supported.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, width of one channel value (uint8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; both are the first two ports below.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_start  input  1  one-cycle pulse that arms one frame.
REQ-007 SHALL have port i_total_pixels  input  32  spatial pixel count (H*W) of the frame; sampled at start.
REQ-008 SHALL have port s_axis_tvalid  input  1  AXIS slave valid.
REQ-009 SHALL have port s_axis_tready  output  1  AXIS slave ready.
REQ-010 SHALL have port s_axis_tdata  input  64  eight bytes; little-endian.
REQ-011 SHALL have port s_axis_tkeep  input  8  byte enables.
REQ-012 SHALL have port s_axis_tlast  input  1  final beat of frame.
REQ-013 SHALL have port o_valid  output  1  pixel pair valid to the conv core.
REQ-014 SHALL have port i_ready  input  1  conv core accepts the pixel pair.
REQ-015 SHALL have port o_data_A  output  8  channel N, taken from the even byte of the lane.
REQ-016 SHALL have port o_data_B  output  8  channel N+1, taken from the odd byte of the lane.
REQ-017 SHALL have port o_last  output  1  high with the final pixel of the frame.
REQ-018 SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-019 SHALL have port o_done  output  1  one-cycle pulse at end of frame.
REQ-020 SHALL have port o_err  output  3  sticky flags: [0] early TLAST, [1] missing or late TLAST, [2] bad TKEEP.

Function
REQ-021 SHALL treat each beat as 4 lanes; lane k = bytes 2k (A) and 2k+1 (B).
- Lane k valid iff tkeep[2k+1:2k]==2'b11.
- Valid lanes are consumed from lane 0 upward and stop at the first invalid lane.
REQ-022 SHALL set o_err[2] for any keep pair of 01 or 10; that lane is treated as invalid.
REQ-023 SHALL implement FSM states IDLE, WAIT_BEAT, UNPACK, DONE.
REQ-024 IDLE: s_axis_tready=0, o_valid=0.
- i_start with total!=0 -> WAIT_BEAT; latch total, clear pixel_cnt and o_err.
- i_start with total==0 -> DONE.
REQ-025 WAIT_BEAT: s_axis_tready=1.
- On handshake, capture tdata/tkeep/tlast into the beat buffer, set lane=0, go to UNPACK.
- A beat with no valid lane 0 is discarded: stay in WAIT_BEAT; if it carries tlast, set o_err[0] and go to DONE.
REQ-026 UNPACK: s_axis_tready=0, o_valid=1, data = current lane.
- o_data_A/B/o_last SHALL hold stable while o_valid && !i_ready.
REQ-027 On o_valid && i_ready in UNPACK:
- pixel_cnt+1.
- If pixel_cnt==total-1: go to DONE; set o_err[1] if buffered tlast==0 or a further valid lane remains.
- Else, if this is the last valid lane of the beat: go to DONE with o_err[0] if buffered tlast==1, otherwise go to WAIT_BEAT.
- Else lane+1.
REQ-028 o_last SHALL equal (pixel_cnt==total-1) while o_valid.
REQ-029 DONE SHALL assert o_done for exactly one cycle, then return to IDLE; the block does not drain leftover stream beats.
REQ-030 Latency: beat handshake at cycle N -> first pixel o_valid at N+1.
- Throughput: one pixel per cycle within a beat, plus one WAIT_BEAT cycle per beat.
REQ-031 i_start SHALL be ignored while o_busy=1.
REQ-032 pixel_cnt SHALL be 32-bit and compared against the latched total only; a change to i_total_pixels mid-frame has no effect.

Reset
REQ-033 rst_n low SHALL asynchronously force the following, including mid-frame; the partial frame is abandoned and no o_done is issued:
- state=IDLE, s_axis_tready=0, o_valid=0;
- o_data_A=0, o_data_B=0, o_last=0, o_busy=0, o_done=0, o_err=0;
- pixel_cnt=0, lane=0, beat buffer=0.

Verification
REQ-034 Full beats: total=8, beats 0x0807060504030201 then 0x100F0E0D0C0B0A09 (tkeep=FF, tlast on the 2nd), i_ready=1 -> 8 pairs (A,B) = (01,02)..(0F,10); o_last on the 8th; o_done one cycle later; o_err=0.
REQ-035 Partial last beat: total=5, beat 2 has tkeep=03 and tlast -> 5 pairs; beat 2 yields only (11,12) with o_last=1; o_err=0.
REQ-036 Backpressure: i_ready toggled 1010... during test 034 -> same 8 pairs in order, each held stable while stalled; no pair duplicated or lost.
REQ-037 TLAST errors:
- total=8 with tlast on beat 1 -> o_err=3'b001 after 4 pixels, o_done.
- total=4 with beat 1 not tlast -> o_err=3'b010 after 4 pixels.
REQ-038 Bad keep: tkeep=8'h07 with tlast, total=1 -> o_err[2]=1; pair (01,02) delivered.
REQ-039 Reset mid-frame: assert rst_n low during UNPACK lane 2 -> all outputs 0 immediately; a subsequent i_start runs a clean frame.

Source files
------------

// File: rtl/feature_map_loader_axis.sv
// Unpacks 64-bit AXI-Stream beats from the DMA into (A,B) uint8 channel pairs
// for the conv core, one lane per cycle, with frame-length and TLAST/TKEEP checking.
module feature_map_loader_axis #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int PIXEL_WIDTH     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_start,
   input  logic [31:0]                  i_total_pixels,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                         s_axis_tlast,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [PIXEL_WIDTH-1:0]       o_data_A,
   output logic [PIXEL_WIDTH-1:0]       o_data_B,
   output logic                         o_last,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [2:0]                   o_err
);

   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, WAIT_BEAT, UNPACK, DONE} state_t;

   state_t                       state_q, state_d;
   logic [31:0]                  total_q, total_d;
   logic [31:0]                  pixel_cnt_q, pixel_cnt_d;
   logic [1:0]                   lane_q, lane_d;
   logic [AXIS_DATA_WIDTH-1:0]   beat_data_q, beat_data_d;
   logic [KEEP_W-1:0]            beat_keep_q, beat_keep_d;
   logic                         beat_last_q, beat_last_d;
   logic [2:0]                   err_q, err_d;

   logic [3:0] in_ok, buf_ok, ok_above;
   logic       in_bad_keep, more_lanes, final_pixel;
   logic [5:0] base_a, base_b;

   // A lane is usable only when both of its bytes are kept.
   function automatic logic [3:0] lanes_ok(input logic [KEEP_W-1:0] keep);
      logic [3:0] ok;
      for (int k = 0; k < 4; k++) ok[k] = (keep[2*k +: 2] == 2'b11);
      return ok;
   endfunction

   function automatic logic keep_malformed(input logic [KEEP_W-1:0] keep);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) bad = bad | (^keep[2*k +: 2]);
      return bad;
   endfunction

   always_comb begin
      in_ok       = lanes_ok(s_axis_tkeep);
      in_bad_keep = keep_malformed(s_axis_tkeep);
      buf_ok      = lanes_ok(beat_keep_q);
      ok_above    = buf_ok >> ({1'b0, lane_q} + 3'd1);
      more_lanes  = (lane_q != 2'd3) && ok_above[0];
      final_pixel = (pixel_cnt_q == total_q - 32'd1);
      base_a      = {lane_q, 4'b0000};
      base_b      = base_a + 6'd8;
   end

   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      pixel_cnt_d = pixel_cnt_q;
      lane_d      = lane_q;
      beat_data_d = beat_data_q;
      beat_keep_d = beat_keep_q;
      beat_last_d = beat_last_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               err_d = 3'b000;
               if (i_total_pixels != 32'd0) begin
                  total_d     = i_total_pixels;
                  pixel_cnt_d = 32'd0;
                  state_d     = WAIT_BEAT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         WAIT_BEAT: begin
            if (s_axis_tvalid) begin
               if (in_bad_keep) err_d[2] = 1'b1;
               if (in_ok[0]) begin
                  beat_data_d = s_axis_tdata;
                  beat_keep_d = s_axis_tkeep;
                  beat_last_d = s_axis_tlast;
                  lane_d      = 2'd0;
                  state_d     = UNPACK;
               end else if (s_axis_tlast) begin
                  // Empty beat closing the frame: stream ended before the pixel count.
                  err_d[0] = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         UNPACK: begin
            if (i_ready) begin
               pixel_cnt_d = pixel_cnt_q + 32'd1;
               if (final_pixel) begin
                  state_d = DONE;
                  if (!beat_last_q || more_lanes) err_d[1] = 1'b1;
               end else if (!more_lanes) begin
                  if (beat_last_q) begin
                     err_d[0] = 1'b1;
                     state_d  = DONE;
                  end else begin
                     state_d = WAIT_BEAT;
                  end
               end else begin
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         total_q     <= '0;
         pixel_cnt_q <= '0;
         lane_q      <= '0;
         beat_data_q <= '0;
         beat_keep_q <= '0;
         beat_last_q <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         pixel_cnt_q <= pixel_cnt_d;
         lane_q      <= lane_d;
         beat_data_q <= beat_data_d;
         beat_keep_q <= beat_keep_d;
         beat_last_q <= beat_last_d;
         err_q       <= err_d;
      end
   end

   // Outputs decode straight from registered state, so reset clears them at once.
   always_comb begin
      s_axis_tready = (state_q == WAIT_BEAT);
      o_valid       = (state_q == UNPACK);
      o_data_A      = o_valid ? beat_data_q[base_a +: PIXEL_WIDTH] : '0;
      o_data_B      = o_valid ? beat_data_q[base_b +: PIXEL_WIDTH] : '0;
      o_last        = o_valid && final_pixel;
      o_busy        = (state_q != IDLE);
      o_done        = (state_q == DONE);
      o_err         = err_q;
   end

endmodule
